// File: rtl/rom_arb_pkg.sv
// Shared types and address helpers for the instruction-ROM arbiter.
// Build option: ROM_ARB_RR_EN selects round-robin arbitration (default: load-over-fetch priority).
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_LD = 2'd2
    } rom_arb_state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LD = 1'b1
    } rom_req_id_t;

    // Helpers work on a fixed 32-bit view; callers zero-extend narrower addresses.
    localparam int unsigned HELPER_W = 32;

    function automatic logic [HELPER_W-1:0] addr_to_idx(input logic [HELPER_W-1:0] addr);
        return addr >> 2;
    endfunction

    function automatic logic is_aligned(input logic [HELPER_W-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

    function automatic logic in_range(input logic [HELPER_W-1:0] idx, input int unsigned n_rows);
        return idx < n_rows;
    endfunction

endpackage

// File: rtl/rom_grant.sv
// Two-requester grant logic for the ROM arbiter; one-hot output {ld, if}.
// Build option: ROM_ARB_RR_EN makes ties alternate using the last-grant pointer.
module rom_grant
    import rom_arb_pkg::*;
(
    input  logic        if_valid,
    input  logic        ld_valid,
    input  logic        slot_free,
    input  rom_req_id_t ptr,
    output logic [1:0]  gnt
);

`ifdef ROM_ARB_RR_EN
    // Tie goes to the port that was not granted last; otherwise the lone requester wins.
    always_comb begin
        gnt = 2'b00;
        if (slot_free) begin
            if (if_valid && ld_valid) begin
                gnt = (ptr == REQ_LD) ? 2'b01 : 2'b10;
            end else begin
                gnt = {ld_valid, if_valid};
            end
        end
    end
`else
    // The pointer has no role under fixed priority.
    logic ptr_unused;
    assign ptr_unused = ptr;

    // Load port always beats the fetch port.
    always_comb begin
        gnt = 2'b00;
        if (slot_free) begin
            if (ld_valid) begin
                gnt = 2'b10;
            end else if (if_valid) begin
                gnt = 2'b01;
            end
        end
    end
`endif

endmodule

// File: rtl/rom_arbiter.sv
// Single-port instruction-ROM arbiter: grants fetch or load, drives the ROM index,
// registers the word (or an error) and returns it to the issuing port.
// Build option: ROM_ARB_RR_EN enables round-robin arbitration with a last-grant pointer.
module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int          ADDR_W = 16,
    parameter int          DATA_W = 32,
    parameter int unsigned N_ROWS = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    output logic              ld_resp_valid,
    input  logic              ld_resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic [ADDR_W-1:0] rom_a,
    input  logic [DATA_W-1:0] rom_spo
);

    rom_arb_state_t        state;
    rom_req_id_t           ptr;
    logic                  slot_free;
    logic [1:0]            gnt;          // bit 1 = load, bit 0 = fetch
    logic [ADDR_W-1:0]     gnt_addr;
    logic [HELPER_W-1:0]   addr_ext;
    logic [HELPER_W-1:0]   idx_ext;
    logic                  req_ok;

    // The slot frees when nothing is held or the held response is consumed this cycle.
    always_comb begin
        slot_free = 1'b1;
        unique case (state)
            IDLE:    slot_free = 1'b1;
            RESP_IF: slot_free = if_resp_ready;
            RESP_LD: slot_free = ld_resp_ready;
            default: slot_free = 1'b1;
        endcase
    end

`ifdef ROM_ARB_RR_EN
    // Remember which port won the last accept; starts as fetch so the first tie goes to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= REQ_IF;
        end else if (gnt[1]) begin
            ptr <= REQ_LD;
        end else if (gnt[0]) begin
            ptr <= REQ_IF;
        end
    end
`else
    assign ptr = REQ_IF;
`endif

    rom_grant u_grant (
        .if_valid  (if_req_valid),
        .ld_valid  (ld_req_valid),
        .slot_free (slot_free),
        .ptr       (ptr),
        .gnt       (gnt)
    );

    // Grant is already gated by valid, so ready is the grant itself.
    assign if_req_ready = gnt[0];
    assign ld_req_ready = gnt[1];

    // Address mux: index 0 when nothing is granted.
    always_comb begin
        gnt_addr = '0;
        if (gnt[1]) begin
            gnt_addr = ld_req_addr;
        end else if (gnt[0]) begin
            gnt_addr = if_req_addr;
        end
    end

    assign addr_ext = HELPER_W'(gnt_addr);
    assign idx_ext  = addr_to_idx(addr_ext);
    assign rom_a    = ADDR_W'(idx_ext);
    assign req_ok   = is_aligned(addr_ext) && in_range(idx_ext, N_ROWS);

    // Response FSM: on accept, latch the word (or zero plus error) and flag the owning port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            if_resp_valid <= 1'b0;
            ld_resp_valid <= 1'b0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
        end else if (slot_free) begin
            if (gnt[1]) begin
                state         <= RESP_LD;
                ld_resp_valid <= 1'b1;
                if_resp_valid <= 1'b0;
            end else if (gnt[0]) begin
                state         <= RESP_IF;
                if_resp_valid <= 1'b1;
                ld_resp_valid <= 1'b0;
            end else begin
                state         <= IDLE;
                if_resp_valid <= 1'b0;
                ld_resp_valid <= 1'b0;
            end
            if (gnt != 2'b00) begin
                resp_data <= req_ok ? rom_spo : '0;
                resp_err  <= ~req_ok;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter with a behavioural asynchronous ROM.
// Honours ROM_ARB_RR_EN for the back-to-back grant pattern.
module tb_rom_arbiter;

    localparam int          ADDR_W = 16;
    localparam int          DATA_W = 32;
    localparam int unsigned N_ROWS = 512;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req_valid = 1'b0;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr = '0;
    logic              if_resp_valid;
    logic              if_resp_ready = 1'b0;
    logic              ld_req_valid = 1'b0;
    logic              ld_req_ready;
    logic [ADDR_W-1:0] ld_req_addr = '0;
    logic              ld_resp_valid;
    logic              ld_resp_ready = 1'b0;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [ADDR_W-1:0] rom_a;
    logic [DATA_W-1:0] rom_spo;

    always #5 clk = ~clk;

    rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_ROWS(N_ROWS)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_ready (if_resp_ready),
        .ld_req_valid  (ld_req_valid),
        .ld_req_ready  (ld_req_ready),
        .ld_req_addr   (ld_req_addr),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_ready (ld_resp_ready),
        .resp_data     (resp_data),
        .resp_err      (resp_err),
        .rom_a         (rom_a),
        .rom_spo       (rom_spo)
    );

    logic [31:0] mem [0:511];
    assign rom_spo = (rom_a < 16'd512) ? mem[rom_a[8:0]] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic        port;   // 1 = load, 0 = fetch
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    resp_t obs_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic resp_t model(input logic port, input logic [15:0] a);
        resp_t       r;
        logic [15:0] idx;
        idx    = a >> 2;
        r.port = port;
        if (a[1:0] != 2'b00 || idx >= 16'd512) begin
            r.data = '0;
            r.err  = 1'b1;
        end else begin
            r.data = mem[idx[8:0]];
            r.err  = 1'b0;
        end
        return r;
    endfunction

    // Scoreboard feed: expected on each accept, observed on each response handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_resp_valid && if_resp_ready) obs_q.push_back({1'b0, resp_data, resp_err});
            if (ld_resp_valid && ld_resp_ready) obs_q.push_back({1'b1, resp_data, resp_err});
            if (ld_req_valid && ld_req_ready) exp_q.push_back(model(1'b1, ld_req_addr));
            if (if_req_valid && if_req_ready) exp_q.push_back(model(1'b0, if_req_addr));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (if_resp_valid !== 1'b0 || ld_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: if=%b ld=%b, want 0 0", if_resp_valid, ld_resp_valid);
        end
        n_checks++;
        if (resp_data !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: data=%h err=%b, want 0 0", resp_data, resp_err);
        end
        n_checks++;
        if (rom_a !== 16'h0 || if_req_ready !== 1'b0 || ld_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: rom_a=%h if_rdy=%b ld_rdy=%b, want 0 0 0", rom_a, if_req_ready, ld_req_ready);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_fetch();
        resp_t o, e;
        if_resp_ready = 1'b1;
        ld_resp_ready = 1'b1;
        if_req_valid  = 1'b1;
        if_req_addr   = 16'h0008;
        @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1 || rom_a !== 16'd2) begin
            n_fail++;
            $display("FAIL single_grant: if_rdy=%b rom_a=%h, want 1 0002", if_req_ready, rom_a);
        end
        tick();
        if_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if_resp_valid !== 1'b1 || ld_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_latency: if_vld=%b ld_vld=%b, want 1 0", if_resp_valid, ld_resp_valid);
        end
        n_checks++;
        if (resp_data !== 32'h0000_0033 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL single_data: data=%h err=%b, want 00000033 0", resp_data, resp_err);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (if_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: if_vld=%b, want 0", if_resp_valid);
        end
        tick();
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_sb: response port=%0d, want none", o.port);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL single_sb: got port=%0d data=%h err=%b, want port=%0d data=%h err=%b", o.port, o.data, o.err, e.port, e.data, e.err);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_left: %0d outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_tie();
        resp_t o, e;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0010;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0000;
        @(negedge clk);
        n_checks++;
        if (ld_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL tie_first: ld_rdy=%b if_rdy=%b, want 1 0", ld_req_ready, if_req_ready);
        end
        tick();
        ld_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ld_resp_valid !== 1'b1 || if_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_second: ld_vld=%b if_rdy=%b, want 1 1", ld_resp_valid, if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if_resp_valid !== 1'b1 || resp_data !== mem[0]) begin
            n_fail++;
            $display("FAIL tie_if_resp: if_vld=%b data=%h, want 1 %h", if_resp_valid, resp_data, mem[0]);
        end
        tick();
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL tie_sb: response port=%0d, want none", o.port);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL tie_sb: got port=%0d data=%h err=%b, want port=%0d data=%h err=%b", o.port, o.data, o.err, e.port, e.data, e.err);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL tie_left: %0d outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        resp_t o, e;
        bit    exp_ld [4];
`ifdef ROM_ARB_RR_EN
        exp_ld = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ld = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0020;
        if_req_valid = 1'b1;
        if_req_addr  = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (!(if_resp_valid === 1'b1 || ld_resp_valid === 1'b1)) begin
                    n_fail++;
                    $display("FAIL b2b_resp[%0d]: if_vld=%b ld_vld=%b, want one high", i, if_resp_valid, ld_resp_valid);
                end
            end
            n_checks++;
            if (ld_req_ready !== exp_ld[i] || if_req_ready !== !exp_ld[i]) begin
                n_fail++;
                $display("FAIL b2b_grant[%0d]: ld_rdy=%b if_rdy=%b, want %b %b", i, ld_req_ready, if_req_ready, exp_ld[i], !exp_ld[i]);
            end
            tick();
            if (exp_ld[i]) ld_req_addr = ld_req_addr + 16'd4;
            else if_req_addr = if_req_addr + 16'd4;
        end
        ld_req_valid = 1'b0;
        if_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!(if_resp_valid === 1'b1 || ld_resp_valid === 1'b1)) begin
            n_fail++;
            $display("FAIL b2b_last: if_vld=%b ld_vld=%b, want one high", if_resp_valid, ld_resp_valid);
        end
        tick();
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL b2b_sb: response port=%0d, want none", o.port);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL b2b_sb: got port=%0d data=%h err=%b, want port=%0d data=%h err=%b", o.port, o.data, o.err, e.port, e.data, e.err);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_left: %0d outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_backpressure();
        resp_t o, e;
        if_resp_ready = 1'b0;
        ld_resp_ready = 1'b1;
        if_req_valid  = 1'b1;
        if_req_addr   = 16'h000C;
        @(negedge clk);
        n_checks++;
        if (if_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept: if_rdy=%b, want 1", if_req_ready);
        end
        tick();
        if_req_valid = 1'b0;
        ld_req_valid = 1'b1;
        ld_req_addr  = 16'h0014;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (if_resp_valid !== 1'b1 || resp_data !== mem[3] || ld_req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: if_vld=%b data=%h ld_rdy=%b, want 1 %h 0", i, if_resp_valid, resp_data, ld_req_ready, mem[3]);
            end
            tick();
        end
        if_resp_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ld_req_ready !== 1'b1 || if_resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: ld_rdy=%b if_vld=%b, want 1 1", ld_req_ready, if_resp_valid);
        end
        tick();
        ld_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ld_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || resp_data !== mem[5]) begin
            n_fail++;
            $display("FAIL bp_ld_resp: ld_vld=%b if_vld=%b data=%h, want 1 0 %h", ld_resp_valid, if_resp_valid, resp_data, mem[5]);
        end
        tick();
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bp_sb: response port=%0d, want none", o.port);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL bp_sb: got port=%0d data=%h err=%b, want port=%0d data=%h err=%b", o.port, o.data, o.err, e.port, e.data, e.err);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_left: %0d outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_boundary();
        resp_t       o, e;
        logic [15:0] addrs     [3];
        logic [31:0] want_data [3];
        logic        want_err  [3];
        addrs     = '{16'h0002, 16'h0800, 16'h07FC};
        want_data = '{32'h0, 32'h0, 32'hC0DE_01FF};
        want_err  = '{1'b1, 1'b1, 1'b0};
        if_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_req_valid = 1'b1;
            if_req_addr  = addrs[i];
            @(negedge clk);
            n_checks++;
            if (if_req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL bound_accept[%h]: if_rdy=%b, want 1", addrs[i], if_req_ready);
            end
            tick();
            if_req_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (if_resp_valid !== 1'b1 || resp_data !== want_data[i] || resp_err !== want_err[i]) begin
                n_fail++;
                $display("FAIL bound_resp[%h]: vld=%b data=%h err=%b, want 1 %h %b", addrs[i], if_resp_valid, resp_data, resp_err, want_data[i], want_err[i]);
            end
            tick();
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL bound_sb: response port=%0d, want none", o.port);
            end else begin
                e = exp_q.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL bound_sb: got port=%0d data=%h err=%b, want port=%0d data=%h err=%b", o.port, o.data, o.err, e.port, e.data, e.err);
                end
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bound_left: %0d outstanding, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        ld_resp_ready = 1'b0;
        ld_req_valid  = 1'b1;
        ld_req_addr   = 16'h0018;
        @(negedge clk);
        n_checks++;
        if (ld_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_accept: ld_rdy=%b, want 1", ld_req_ready);
        end
        tick();
        ld_req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ld_resp_valid !== 1'b1 || resp_data !== mem[6]) begin
            n_fail++;
            $display("FAIL rmid_held: ld_vld=%b data=%h, want 1 %h", ld_resp_valid, resp_data, mem[6]);
        end
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++;
        if (ld_resp_valid !== 1'b0 || if_resp_valid !== 1'b0 || resp_data !== 32'h0 || resp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_reset: ld_vld=%b if_vld=%b data=%h err=%b, want 0 0 0 0", ld_resp_valid, if_resp_valid, resp_data, resp_err);
        end
        tick();
        rst = 1'b0;
        ld_resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (ld_resp_valid !== 1'b0 || if_resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rmid_stale[%0d]: ld_vld=%b if_vld=%b, want 0 0", i, ld_resp_valid, if_resp_valid);
            end
            tick();
        end
        n_checks++;
        if (exp_q.size() != 1 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL rmid_sb: dropped=%0d observed=%0d, want 1 0", exp_q.size(), obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE_0000 | i;
        mem[2] = 32'h0000_0033;
        test_reset();
        test_single_fetch();
        test_tie();
        test_back_to_back();
        test_backpressure();
        test_boundary();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
